// File: rtl/multicycle_core.sv
// Multicycle 16-bit-instruction core: FETCH/EXEC/MEM/HALT sequencer
// with separate valid/ready instruction and data ports.
module multicycle_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  input  logic              imem_ready,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ready,
  output logic [ADDR_W-1:0] pc_out,
  output logic [DATA_W-1:0] alu_result,
  output logic              zero,
  output logic              carry,
  output logic              halted,
  output logic              illegal
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] pc, pc_inc, br_tgt;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [15:0]       ir;
  logic [DATA_W-1:0] rf [4];
  logic [DATA_W-1:0] alu_q;
  logic              zero_q, carry_q, illegal_q;

  logic [3:0]        op;
  logic [1:0]        rd, rs;
  logic [7:0]        imm;
  logic [DATA_W-1:0] a, b;
  logic [DATA_W-1:0] imm_sd, imm_zd;
  logic [ADDR_W-1:0] imm_sa, imm_za;

  assign op  = ir[15:12];
  assign rd  = ir[11:10];
  assign rs  = ir[9:8];
  assign imm = ir[7:0];
  assign a   = rf[rd];
  assign b   = rf[rs];

  assign imm_sd = DATA_W'($signed(imm));
  assign imm_zd = DATA_W'(imm);
  assign imm_sa = ADDR_W'($signed(imm));
  assign imm_za = ADDR_W'(imm);

  assign pc_inc = pc + ADDR_W'(1);
  assign br_tgt = pc_inc + imm_sa;

  logic is_nop, is_alu, is_li, is_ld, is_st;
  logic is_beqz, is_jmp, is_halt, is_ill;

  always_comb begin
    is_nop  = (op == 4'h0);
    is_alu  = (op >= 4'h1 && op <= 4'h5) || (op == 4'h7);
    is_li   = (op == 4'h6);
    is_ld   = (op == 4'h8);
    is_st   = (op == 4'h9);
    is_beqz = (op == 4'hA);
    is_jmp  = (op == 4'hB);
    is_halt = (op == 4'hF);
    is_ill  = (op >= 4'hC && op <= 4'hE);
  end

  logic [DATA_W-1:0] alu_sum;
  logic              alu_c;

  always_comb begin
    alu_sum = '0;
    alu_c   = 1'b0;
    unique case (op)
      4'h1: {alu_c, alu_sum} = {1'b0, a} + {1'b0, b};
      4'h2: begin
        alu_sum = a - b;
        alu_c   = (a < b);
      end
      4'h3: alu_sum = a & b;
      4'h4: alu_sum = a | b;
      4'h5: alu_sum = a ^ b;
      4'h7: {alu_c, alu_sum} = {1'b0, a} + {1'b0, imm_sd};
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_FETCH: if (imem_ready) state_nx = S_EXEC;
      S_EXEC: begin
        unique case (1'b1)
          is_ld, is_st: state_nx = S_MEM;
          is_halt:      state_nx = S_HALT;
          default:      state_nx = S_FETCH;
        endcase
      end
      S_MEM:  if (dmem_ready) state_nx = S_FETCH;
      S_HALT: state_nx = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_nx;
  end

  // Reset has priority, so an aborted access never commits.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc        <= RESET_PC;
      ir        <= '0;
      for (int i = 0; i < 4; i++) rf[i] <= '0;
      alu_q     <= '0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      illegal_q <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      unique case (state)
        S_FETCH: if (imem_ready) ir <= imem_rdata;
        S_EXEC: begin
          unique case (1'b1)
            is_alu: begin
              rf[rd]  <= alu_sum;
              alu_q   <= alu_sum;
              zero_q  <= (alu_sum == '0);
              carry_q <= alu_c;
              pc      <= pc_inc;
            end
            is_li: begin
              rf[rd] <= imm_zd;
              pc     <= pc_inc;
            end
            is_beqz: pc <= (a == '0) ? br_tgt : pc_inc;
            is_jmp:  pc <= imm_za;
            is_ld, is_st: begin
              mem_addr  <= ADDR_W'(b) + imm_sa;
              mem_wdata <= a;
              mem_we    <= is_st;
            end
            is_halt: ;
            is_ill: begin
              illegal_q <= 1'b1;
              pc        <= pc_inc;
            end
            is_nop:  pc <= pc_inc;
            default: pc <= pc_inc;
          endcase
        end
        S_MEM: begin
          if (dmem_ready) begin
            if (!mem_we) rf[rd] <= dmem_rdata;
            pc <= pc_inc;
          end
        end
        S_HALT: ;
      endcase
    end
  end

  assign imem_req   = (state == S_FETCH);
  assign imem_addr  = pc;
  assign dmem_req   = (state == S_MEM);
  assign dmem_we    = dmem_req & mem_we;
  assign dmem_addr  = mem_addr;
  assign dmem_wdata = mem_wdata;
  assign pc_out     = pc;
  assign alu_result = alu_q;
  assign zero       = zero_q;
  assign carry      = carry_q;
  assign halted     = (state == S_HALT);
  assign illegal    = illegal_q;

endmodule
